uart_apb_master: RTL and testbench
==================================

UART_APB_MASTER -- requirements
Module: uart_apb_master

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, command FIFO entries (power of two, 2..16).
REQ-002 Port: PCLK  in  1  single clock; all logic SHALL be rising-edge on PCLK.
REQ-003 Port: PRESETn  in  1  synchronous active-low reset.
REQ-004 Port: cmd_valid  in  1  command request.
REQ-005 Port: cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge.
REQ-006 Port: cmd_write  in  1  1 = write, 0 = read.
REQ-007 Port: cmd_addr  in  10  word address, maps to PADDR[11:2].
REQ-008 Port: cmd_wdata  in  16  write data (ignored for reads).
REQ-009 Port: rsp_valid  out  1  read data available.
REQ-010 Port: rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
REQ-011 Port: rsp_rdata  out  16  captured PRDATA.
REQ-012 Port: busy  out  1  high when FSM not IDLE or FIFO non-empty.
REQ-013 Ports: PSEL out 1, PENABLE out 1, PWRITE out 1, PADDR out [11:2], PWDATA out 16, PRDATA in 16 -- APB2 initiator; there is no PREADY/PSLVERR, so every transfer is exactly SETUP + one ACCESS cycle.

Function
REQ-014 cmd_ready SHALL equal !fifo_full; there is no push-on-full and no bypass path.
REQ-015 Each accepted command SHALL be pushed as {write, addr, wdata}; commands SHALL issue in strict acceptance order.
REQ-016 FSM states SHALL be IDLE, SETUP, ACCESS, RSP.
REQ-017 IDLE: if FIFO non-empty, pop the head into the transfer registers and go to SETUP; otherwise stay in IDLE.
REQ-018 SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA driven from the popped entry; always go to ACCESS.
REQ-019 ACCESS: PSEL=1, PENABLE=1, same address/data. On exit:
  - Read: capture PRDATA into rsp_rdata, assert rsp_valid, go to RSP.
  - Write: if FIFO non-empty, pop and go to SETUP (back-to-back, no idle cycle); otherwise go to IDLE.
REQ-020 RSP: PSEL=0, PENABLE=0; hold rsp_valid and rsp_rdata stable until rsp_ready. On the handshake edge, deassert rsp_valid, then pop and go to SETUP if the FIFO is non-empty, else go to IDLE.
REQ-021 Latency, command accepted at edge E into an empty FIFO with FSM in IDLE:
  - SETUP after E+1;
  - ACCESS after E+2;
  - for reads, rsp_valid=1 after E+3.
REQ-022 PWRITE/PADDR/PWDATA SHALL hold their last transfer values outside SETUP/ACCESS; PWDATA SHALL be 16'h0000 for read transfers.
REQ-023 A push and a pop on the same edge SHALL leave the occupancy count unchanged; the count SHALL never exceed FIFO_DEPTH or drop below 0.
REQ-024 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 PENABLE SHALL never be high without PSEL.
REQ-026 PSEL SHALL never stay high for more than two consecutive cycles per transfer.

Reset
REQ-027 When PRESETn=0 at a rising edge:
  - FSM to IDLE, FIFO flushed;
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, busy all 0;
  - cmd_ready=1 after the first edge with PRESETn=1.
REQ-028 Reset asserted mid-transfer (SETUP, ACCESS or RSP) SHALL abort the transfer with no response and no further APB activity.
REQ-029 cmd_valid SHALL be ignored while PRESETn=0.

Structure
REQ-030 Package uart_apb_pkg SHALL hold:
  - ADDR_W=10 and DATA_W=16;
  - the state enum {IDLE, SETUP, ACCESS, RSP};
  - the packed command struct {write, addr, wdata}.
REQ-031 The FIFO SHALL be a separate sub-module, uart_apb_cmd_fifo, parameterised by depth and element type, exposing push, pop, full, empty and head.

Verification
REQ-032 Write 0x0301 to addr 0x00C (UARTCR):
  - SETUP after E+1 with PSEL=1, PENABLE=0, PWRITE=1, PADDR=0x00C, PWDATA=0x0301;
  - ACCESS after E+2;
  - idle after E+3;
  - no rsp_valid.
REQ-033 Read addr 0x006 (UARTFR) with slave PRDATA=0x0090 and rsp_ready=1:
  - rsp_valid=1 and rsp_rdata=0x0090 for exactly one cycle;
  - PWDATA=0 during the transfer.
REQ-034 Four writes to addrs 0x009, 0x00A, 0x00B, 0x00C pushed on consecutive cycles:
  - cmd_ready falls only when occupancy reaches 4;
  - transfers issue back-to-back, 8 consecutive PSEL cycles in order;
  - busy falls after the last ACCESS.
REQ-035 Read addr 0x000 with rsp_ready=0 for 5 cycles and a queued write behind it:
  - rsp_valid and rsp_rdata held stable for 5 cycles;
  - the write SETUP starts only after the rsp handshake.
REQ-036 PRESETn=0 during ACCESS with 2 commands queued:
  - next cycle all outputs 0 and the FIFO empty;
  - no rsp_valid;
  - after release, a new command issues normally.

Source files
------------

// File: rtl/uart_apb_pkg.sv
// rtl/uart_apb_pkg.sv - shared widths, FSM state and command type for uart_apb_master
// Contents: ADDR_W/DATA_W, state_t {IDLE, SETUP, ACCESS, RSP}, cmd_t {write, addr, wdata}.
package uart_apb_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RSP
  } state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/uart_apb_master_if.sv
// rtl/uart_apb_master_if.sv - command/response handshake and APB2 bus bundle
// master: the bridge (drives cmd_ready, rsp_*, busy, PSEL/PENABLE/PWRITE/PADDR/PWDATA).
// slave : the environment (drives cmd_*, rsp_ready, PRDATA).
interface uart_apb_master_if;
  import uart_apb_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W+1:2] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA,
    output cmd_ready, rsp_valid, rsp_rdata, busy,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA,
    input  cmd_ready, rsp_valid, rsp_rdata, busy,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

endinterface

// File: rtl/uart_apb_cmd_fifo.sv
// rtl/uart_apb_cmd_fifo.sv - synchronous command FIFO, DEPTH entries of type T
// Ports: clk, resetn (sync active-low), push/din, pop, full, empty, head (entry at read pointer).
module uart_apb_cmd_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  T     din,
  input  logic pop,
  output logic full,
  output logic empty,
  output T     head
);

  localparam int PTR_W = $clog2(DEPTH);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally at PTR_W bits.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_apb_master.sv
// rtl/uart_apb_master.sv - queued command to APB2 initiator bridge
// Ports: PCLK, PRESETn (sync active-low), bus (uart_apb_master_if.master):
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata in, rsp_valid/rsp_ready/rsp_rdata out,
//   busy, PSEL/PENABLE/PWRITE/PADDR/PWDATA out, PRDATA in.
module uart_apb_master
  import uart_apb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  uart_apb_master_if.master bus
);

  state_t            state;
  state_t            next_state;
  cmd_t              push_cmd;
  cmd_t              head;
  cmd_t              xfer;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              capture;
  logic [DATA_W-1:0] rdata_q;

  assign push_cmd = {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};

  uart_apb_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (cmd_t)
  ) u_fifo (
    .clk    (PCLK),
    .resetn (PRESETn),
    .push   (bus.cmd_valid),
    .din    (push_cmd),
    .pop    (pop),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (head)
  );

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          next_state = SETUP;
        end
      end
      SETUP: next_state = ACCESS;
      ACCESS: begin
        if (!xfer.write) begin
          capture    = 1'b1;
          next_state = RSP;
        end else if (!fifo_empty) begin
          pop        = 1'b1;
          next_state = SETUP;
        end else begin
          next_state = IDLE;
        end
      end
      RSP: begin
        if (bus.rsp_ready) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            next_state = SETUP;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // The transfer registers feed the APB address/data pins directly, so they
  // keep the last transfer's values while idle; read transfers store zero data.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state   <= IDLE;
      xfer    <= '0;
      rdata_q <= '0;
    end else begin
      state <= next_state;
      if (pop) begin
        xfer.write <= head.write;
        xfer.addr  <= head.addr;
        xfer.wdata <= head.write ? head.wdata : '0;
      end
      if (capture) rdata_q <= bus.PRDATA;
    end
  end

  assign bus.cmd_ready = !fifo_full;
  assign bus.PSEL      = (state == SETUP) || (state == ACCESS);
  assign bus.PENABLE   = (state == ACCESS);
  assign bus.PWRITE    = xfer.write;
  assign bus.PADDR     = xfer.addr;
  assign bus.PWDATA    = xfer.wdata;
  assign bus.rsp_valid = (state == RSP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.busy      = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_apb_master.sv
// tb/tb_uart_apb_master.sv - directed self-checking bench for uart_apb_master
module tb_uart_apb_master;
  import uart_apb_pkg::*;

  logic pclk = 1'b0;
  logic presetn;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 pclk = ~pclk;

  uart_apb_master_if bus();

  uart_apb_master #(.FIFO_DEPTH(4)) dut (
    .PCLK    (pclk),
    .PRESETn (presetn),
    .bus     (bus.master)
  );

  // APB activity log, sampled on the falling edge.
  int          cyc = 0;
  int          log_cyc[$];
  logic [27:0] log_dat[$];
  int          proto_err = 0;
  logic        prev_setup = 1'b0;
  logic        prev_access = 1'b0;
  logic        mon_en = 1'b0;

  always @(negedge pclk) begin
    cyc++;
    if (mon_en) begin
      if (bus.PSEL === 1'b1) begin
        log_cyc.push_back(cyc);
        log_dat.push_back({bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA});
      end
      if (bus.PENABLE && !bus.PSEL) proto_err++;
      if (prev_access && bus.PENABLE) proto_err++;
      if (prev_setup && presetn && !(bus.PSEL && bus.PENABLE)) proto_err++;
      prev_setup  = bus.PSEL && !bus.PENABLE;
      prev_access = bus.PSEL && bus.PENABLE;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic drive_cmd(input logic v, input logic w, input logic [9:0] a, input logic [15:0] d);
    bus.cmd_valid = v;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
  endtask

  task automatic clear_log();
    log_cyc.delete();
    log_dat.delete();
  endtask

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_psel"},    32'(bus.PSEL),      0);
    check({pfx, "_penable"}, 32'(bus.PENABLE),   0);
    check({pfx, "_pwrite"},  32'(bus.PWRITE),    0);
    check({pfx, "_paddr"},   32'(bus.PADDR),     0);
    check({pfx, "_pwdata"},  32'(bus.PWDATA),    0);
    check({pfx, "_rvalid"},  32'(bus.rsp_valid), 0);
    check({pfx, "_rdata"},   32'(bus.rsp_rdata), 0);
    check({pfx, "_busy"},    32'(bus.busy),      0);
  endtask

  // Single write into an idle bridge: SETUP after E+1, ACCESS after E+2, idle after E+3.
  task automatic run_write(input string pfx, input logic [9:0] a, input logic [15:0] d);
    drive_cmd(1'b1, 1'b1, a, d);
    check({pfx, "_ready"}, 32'(bus.cmd_ready), 1);
    tick();
    drive_cmd(1'b0, 1'b0, '0, '0);
    check({pfx, "_e0_psel"}, 32'(bus.PSEL), 0);
    check({pfx, "_e0_busy"}, 32'(bus.busy), 1);
    tick();
    check({pfx, "_setup_psel"},    32'(bus.PSEL),    1);
    check({pfx, "_setup_penable"}, 32'(bus.PENABLE), 0);
    check({pfx, "_setup_pwrite"},  32'(bus.PWRITE),  1);
    check({pfx, "_setup_paddr"},   32'(bus.PADDR),   32'(a));
    check({pfx, "_setup_pwdata"},  32'(bus.PWDATA),  32'(d));
    tick();
    check({pfx, "_access_psel"},    32'(bus.PSEL),    1);
    check({pfx, "_access_penable"}, 32'(bus.PENABLE), 1);
    check({pfx, "_access_paddr"},   32'(bus.PADDR),   32'(a));
    tick();
    check({pfx, "_idle_psel"},   32'(bus.PSEL),      0);
    check({pfx, "_idle_busy"},   32'(bus.busy),      0);
    check({pfx, "_idle_rvalid"}, 32'(bus.rsp_valid), 0);
    check({pfx, "_held_paddr"},  32'(bus.PADDR),     32'(a));
    check({pfx, "_held_pwdata"}, 32'(bus.PWDATA),    32'(d));
  endtask

  initial begin
    logic [9:0]  a;
    logic [15:0] d;
    int          n;

    // Reset with cmd_valid asserted: the command must not be queued.
    presetn       = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.PRDATA    = 16'h0000;
    drive_cmd(1'b1, 1'b1, 10'h155, 16'hABCD);
    tick();
    tick();
    check_idle_outputs("rst");
    presetn = 1'b1;
    drive_cmd(1'b0, 1'b0, '0, '0);
    mon_en = 1'b1;
    tick();
    check("rst_rel_ready", 32'(bus.cmd_ready), 1);
    check("rst_rel_busy",  32'(bus.busy),      0);
    check("rst_rel_psel",  32'(bus.PSEL),      0);

    // Write 0x0301 to UARTCR.
    run_write("wr_cr", 10'h00C, 16'h0301);

    // Read UARTFR, consumed immediately.
    bus.PRDATA    = 16'h0090;
    bus.rsp_ready = 1'b1;
    drive_cmd(1'b1, 1'b0, 10'h006, 16'hFFFF);
    tick();
    drive_cmd(1'b0, 1'b0, '0, '0);
    tick();
    check("rd_setup_psel",   32'(bus.PSEL),    1);
    check("rd_setup_pwrite", 32'(bus.PWRITE),  0);
    check("rd_setup_paddr",  32'(bus.PADDR),   'h006);
    check("rd_setup_pwdata", 32'(bus.PWDATA),  0);
    tick();
    check("rd_access_penable", 32'(bus.PENABLE), 1);
    check("rd_access_pwdata",  32'(bus.PWDATA),  0);
    check("rd_access_rvalid",  32'(bus.rsp_valid), 0);
    tick();
    check("rd_rsp_rvalid", 32'(bus.rsp_valid), 1);
    check("rd_rsp_rdata",  32'(bus.rsp_rdata), 'h0090);
    check("rd_rsp_psel",   32'(bus.PSEL),      0);
    tick();
    check("rd_done_rvalid", 32'(bus.rsp_valid), 0);
    check("rd_done_busy",   32'(bus.busy),      0);

    // Four writes on consecutive cycles: back-to-back transfers.
    clear_log();
    for (int i = 0; i < 4; i++) begin
      drive_cmd(1'b1, 1'b1, 10'(9 + i), 16'(16'hA000 + i));
      check("b2b_ready", 32'(bus.cmd_ready), 1);
      tick();
    end
    drive_cmd(1'b0, 1'b0, '0, '0);
    repeat (5) tick();
    check("b2b_last_access_busy", 32'(bus.busy),    1);
    check("b2b_last_access_pen",  32'(bus.PENABLE), 1);
    check("b2b_last_access_addr", 32'(bus.PADDR),   'h00C);
    tick();
    check("b2b_busy_fall", 32'(bus.busy), 0);
    n = log_cyc.size();
    check("b2b_psel_cycles", 32'(n), 8);
    for (int k = 0; k < 8; k++) begin
      if (k < n) begin
        check("b2b_entry", 32'(log_dat[k]),
              32'({(k % 2 == 1), 1'b1, 10'(9 + k / 2), 16'(16'hA000 + k / 2)}));
        check("b2b_consecutive", 32'(log_cyc[k] - log_cyc[0]), 32'(k));
      end
    end

    // Read held off by rsp_ready=0 with four writes queued behind it (FIFO fills).
    clear_log();
    bus.rsp_ready = 1'b0;
    bus.PRDATA    = 16'h1234;
    drive_cmd(1'b1, 1'b0, 10'h000, 16'h0000);
    check("hold_ready_e0", 32'(bus.cmd_ready), 1);
    tick();
    for (int j = 1; j <= 4; j++) begin
      drive_cmd(1'b1, 1'b1, 10'(10'h100 + j), 16'(16'h5500 + j));
      check("hold_ready_pre", 32'(bus.cmd_ready), 1);
      tick();
      if (j == 3) begin
        check("hold_rvalid_e3", 32'(bus.rsp_valid), 1);
        check("hold_rdata_e3",  32'(bus.rsp_rdata), 'h1234);
      end
    end
    check("hold_full_ready", 32'(bus.cmd_ready), 0);
    check("hold_rvalid_e4",  32'(bus.rsp_valid), 1);
    check("hold_rdata_e4",   32'(bus.rsp_rdata), 'h1234);
    bus.PRDATA = 16'hBEEF;
    drive_cmd(1'b1, 1'b1, 10'h3FF, 16'hDEAD);
    tick();
    drive_cmd(1'b0, 1'b0, '0, '0);
    for (int j = 5; j <= 7; j++) begin
      check("hold_rvalid", 32'(bus.rsp_valid), 1);
      check("hold_rdata",  32'(bus.rsp_rdata), 'h1234);
      check("hold_psel",   32'(bus.PSEL),      0);
      check("hold_ready",  32'(bus.cmd_ready), 0);
      if (j < 7) tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    check("hold_hs_rvalid", 32'(bus.rsp_valid), 0);
    check("hold_hs_psel",   32'(bus.PSEL),      1);
    check("hold_hs_penable",32'(bus.PENABLE),   0);
    check("hold_hs_paddr",  32'(bus.PADDR),     'h101);
    repeat (8) tick();
    check("hold_busy_fall", 32'(bus.busy),      0);
    check("hold_ready_end", 32'(bus.cmd_ready), 1);
    n = log_cyc.size();
    check("hold_psel_cycles", 32'(n), 10);
    if (n >= 2) begin
      check("hold_rd_setup",  32'(log_dat[0]), 32'({1'b0, 1'b0, 10'h000, 16'h0000}));
      check("hold_rd_access", 32'(log_dat[1]), 32'({1'b1, 1'b0, 10'h000, 16'h0000}));
    end
    if (n >= 3) check("hold_wr_after_hs", 32'(log_cyc[2] - log_cyc[1]), 6);
    for (int k = 2; k < 10; k++) begin
      if (k < n) begin
        a = 10'(10'h101 + (k - 2) / 2);
        d = 16'(16'h5501 + (k - 2) / 2);
        check("hold_wr_entry", 32'(log_dat[k]), 32'({(k % 2 == 1), 1'b1, a, d}));
        check("hold_wr_consec", 32'(log_cyc[k] - log_cyc[2]), 32'(k - 2));
      end
    end

    // Reset during ACCESS with two commands queued.
    bus.rsp_ready = 1'b1;
    drive_cmd(1'b1, 1'b1, 10'h020, 16'h1111);
    tick();
    drive_cmd(1'b1, 1'b0, 10'h021, 16'h0000);
    tick();
    drive_cmd(1'b1, 1'b1, 10'h022, 16'h2222);
    tick();
    check("abort_pre_penable", 32'(bus.PENABLE), 1);
    check("abort_pre_paddr",   32'(bus.PADDR),   'h020);
    presetn = 1'b0;
    drive_cmd(1'b1, 1'b0, 10'h023, 16'h0000);
    tick();
    check_idle_outputs("abort");
    tick();
    presetn = 1'b1;
    drive_cmd(1'b0, 1'b0, '0, '0);
    tick();
    check("abort_rel_busy",  32'(bus.busy),      0);
    check("abort_rel_psel",  32'(bus.PSEL),      0);
    check("abort_rel_ready", 32'(bus.cmd_ready), 1);
    tick();
    check("abort_quiet_busy",   32'(bus.busy),      0);
    check("abort_quiet_rvalid", 32'(bus.rsp_valid), 0);
    run_write("post_abort", 10'h030, 16'h7777);

    check("apb_protocol", 32'(proto_err), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
